// File: rtl/vacuum_fsm_ctrl.sv
// Moore controller for the robot vacuum: OFF/ON/CLEANING/EVADING with timed evasion,
// clean-session timeout and a saturating obstacle counter. Define VAC_DOCK_EN for DOCKING.
module vacuum_fsm_ctrl #(
    parameter int EVADE_CYCLES = 16,
    parameter int CLEAN_CYCLES = 1024,
    parameter int OBST_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  power_off,
    input  logic                  power_on,
    input  logic                  clean_req,
    input  logic                  obstacle,
    input  logic                  battery_low,
    input  logic                  dock_reached,
    output logic [2:0]            state,
    output logic                  motor_en,
    output logic                  brush_en,
    output logic                  turn_en,
    output logic                  clean_done,
    output logic [OBST_CNT_W-1:0] obstacle_cnt
);

    localparam int CW = $clog2(CLEAN_CYCLES);
    localparam int EW = $clog2(EVADE_CYCLES + 1);
    localparam logic [CW-1:0] CLEAN_LAST = CW'(CLEAN_CYCLES - 1);
    localparam logic [EW-1:0] EVADE_LOAD = EW'(EVADE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_ON    = 3'd1,
        S_CLEAN = 3'd2,
        S_EVADE = 3'd3,
        S_DOCK  = 3'd4
    } state_t;

    state_t          cur;
    logic [CW-1:0]   cnt_c;
    logic [EW-1:0]   cnt_e;

`ifndef VAC_DOCK_EN
    logic unused_dock_inputs;
    assign unused_dock_inputs = battery_low ^ dock_reached;
`endif

    assign state    = cur;
    assign motor_en = (cur == S_CLEAN) || (cur == S_EVADE) || (cur == S_DOCK);
    assign brush_en = (cur == S_CLEAN);
    assign turn_en  = (cur == S_EVADE);

    // The clean timer holds its value through EVADING so a session resumes where it left off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur          <= S_OFF;
            cnt_c        <= '0;
            cnt_e        <= '0;
            clean_done   <= 1'b0;
            obstacle_cnt <= '0;
        end else begin
            clean_done <= 1'b0;
            case (cur)
                S_OFF: begin
                    if (power_on && !power_off) begin
                        cur          <= S_ON;
                        obstacle_cnt <= '0;
                    end
                end
                S_ON: begin
                    if (power_off) begin
                        cur <= S_OFF;
`ifdef VAC_DOCK_EN
                    end else if (battery_low) begin
                        cur <= S_DOCK;
`endif
                    end else if (clean_req) begin
                        cur   <= S_CLEAN;
                        cnt_c <= '0;
                    end
                end
                S_CLEAN: begin
                    if (power_off) begin
                        cur <= S_OFF;
`ifdef VAC_DOCK_EN
                    end else if (battery_low) begin
                        cur <= S_DOCK;
`endif
                    end else if (cnt_c == CLEAN_LAST) begin
                        cur        <= S_ON;
                        clean_done <= 1'b1;
                    end else if (obstacle) begin
                        cur   <= S_EVADE;
                        cnt_e <= EVADE_LOAD;
                        if (obstacle_cnt != '1) begin
                            obstacle_cnt <= obstacle_cnt + 1'b1;
                        end
                    end else if (!clean_req) begin
                        cur <= S_ON;
                    end else begin
                        cnt_c <= cnt_c + 1'b1;
                    end
                end
                S_EVADE: begin
                    if (power_off) begin
                        cur <= S_OFF;
`ifdef VAC_DOCK_EN
                    end else if (battery_low) begin
                        cur <= S_DOCK;
`endif
                    end else if (obstacle) begin
                        cnt_e <= EVADE_LOAD;
                    end else if (cnt_e == '0) begin
                        cur <= S_CLEAN;
                    end else begin
                        cnt_e <= cnt_e - 1'b1;
                    end
                end
`ifdef VAC_DOCK_EN
                S_DOCK: begin
                    if (power_off || dock_reached) begin
                        cur <= S_OFF;
                    end
                end
`endif
                default: cur <= S_OFF;
            endcase
        end
    end

endmodule
